// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffers of the MIPS core.
//   - state encoding of the 2-entry skid buffer (EMPTY / HALF / FULL)
//   - default payload geometry (WIDTH bits x NCH channels)
//   - channel indices into the flattened payload bus
//   - st_decode(): maps any state word to a legal state (illegal -> EMPTY)
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam int PIPE_WIDTH = 32;
    localparam int PIPE_NCH   = 6;

    // Channel k occupies bits [k*WIDTH +: WIDTH] of the flattened bus.
    localparam int CH_INSTR = 0;
    localparam int CH_PC    = 1;
    localparam int CH_RD1   = 2;
    localparam int CH_RD2   = 3;
    localparam int CH_IMM   = 4;
    localparam int CH_LUI   = 5;

    // The unused encoding 2'd3 is treated as EMPTY so the buffer recovers
    // on its own within one cycle.
    function automatic logic [1:0] st_decode(input logic [1:0] st);
        case (st)
            ST_HALF: return ST_HALF;
            ST_FULL: return ST_FULL;
            default: return ST_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low clear
//   inc    count this cycle (ignored once the counter is at all-ones)
//   cnt    current count
module pipe_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + ONE;
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register (F/D, D/E, E/M, M/W) with valid/ready
// handshake, 2-entry skid buffer and flush-to-bubble.
//
// Optional feature macro: PIPE_PERF_EN (adds stall_cnt / flush_cnt).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   flush      kill held beats, next cycle is a bubble
//   in_valid   upstream payload valid
//   in_ready   buffer can accept (registered state + reset only)
//   in_data    upstream payload, NCH channels of WIDTH bits
//   out_valid  out_data valid (registered state only)
//   out_ready  downstream consumes (0 = hazard stall)
//   out_data   payload to next stage, all-zero when out_valid==0
//   stall_cnt  [PIPE_PERF_EN] saturating count of out_valid & !out_ready
//   flush_cnt  [PIPE_PERF_EN] saturating count of flush cycles
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH,
    parameter int NCH   = PIPE_NCH,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef PIPE_PERF_EN
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
`else
    output logic [NCH*WIDTH-1:0] out_data
`endif
);

    logic [1:0]                 state_q, st_cur, st_nxt;
    logic [NCH-1:0][WIDTH-1:0]  main_q, main_nxt;
    logic [NCH-1:0][WIDTH-1:0]  skid_q, skid_nxt;
    logic                       in_fire, out_fire;

    assign st_cur    = st_decode(state_q);

    // Handshake outputs come from registered state only; the skid entry is
    // what lets in_ready ignore out_ready without losing throughput.
    assign out_valid = (st_cur != ST_EMPTY);
    assign in_ready  = reset && (st_cur != ST_FULL);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // main is already zero whenever the buffer drains normally; the gate
    // also covers recovery from an illegal state word.
    assign out_data  = out_valid ? main_q : '0;

    always_comb begin
        st_nxt   = st_cur;
        main_nxt = main_q;
        skid_nxt = skid_q;
        if (flush) begin
            // A same-cycle out_fire beat was consumed downstream; a
            // same-cycle in_fire beat is dropped.
            st_nxt   = ST_EMPTY;
            main_nxt = '0;
            skid_nxt = '0;
        end else begin
            case (st_cur)
                ST_HALF: begin
                    if (in_fire && out_fire) begin
                        main_nxt = in_data;
                    end else if (in_fire) begin
                        st_nxt   = ST_FULL;
                        skid_nxt = in_data;
                    end else if (out_fire) begin
                        st_nxt   = ST_EMPTY;
                        main_nxt = '0;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        st_nxt   = ST_HALF;
                        main_nxt = skid_q;
                        skid_nxt = '0;
                    end
                end
                default: begin
                    if (in_fire) begin
                        st_nxt   = ST_HALF;
                        main_nxt = in_data;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= st_nxt;
            main_q  <= main_nxt;
            skid_q  <= skid_nxt;
        end
    end

`ifdef PIPE_PERF_EN
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid && !out_ready),
        .cnt   (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush),
        .cnt   (flush_cnt)
    );
`endif

endmodule
